// File: rtl/key_entry_pkg.sv
// key_entry_pkg: shared definitions for the keypad entry buffer.
//   - PS/2 set-2 scan codes for the digit row, Backspace, Esc and Enter
//   - default BCD code for an unlit seven-segment digit
//   - entry state machine encoding
//   - scan_to_digit(): scan code -> {hit, digit}
package key_entry_pkg;

  localparam logic [8:0] SC_0     = 9'h045;
  localparam logic [8:0] SC_1     = 9'h016;
  localparam logic [8:0] SC_2     = 9'h01E;
  localparam logic [8:0] SC_3     = 9'h026;
  localparam logic [8:0] SC_4     = 9'h025;
  localparam logic [8:0] SC_5     = 9'h02E;
  localparam logic [8:0] SC_6     = 9'h036;
  localparam logic [8:0] SC_7     = 9'h03D;
  localparam logic [8:0] SC_8     = 9'h03E;
  localparam logic [8:0] SC_9     = 9'h046;
  localparam logic [8:0] SC_BKSP  = 9'h066;
  localparam logic [8:0] SC_ESC   = 9'h076;
  localparam logic [8:0] SC_ENTER = 9'h05A;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Bit 4 set when the code is a digit key; bits 3:0 carry the digit value.
  // The full 9-bit code is compared so extended (E0-prefixed) keys never alias.
  function automatic logic [4:0] scan_to_digit(input logic [8:0] code);
    logic [4:0] r;
    r = 5'b0;
    case (code)
      SC_0:    r = {1'b1, 4'd0};
      SC_1:    r = {1'b1, 4'd1};
      SC_2:    r = {1'b1, 4'd2};
      SC_3:    r = {1'b1, 4'd3};
      SC_4:    r = {1'b1, 4'd4};
      SC_5:    r = {1'b1, 4'd5};
      SC_6:    r = {1'b1, 4'd6};
      SC_7:    r = {1'b1, 4'd7};
      SC_8:    r = {1'b1, 4'd8};
      SC_9:    r = {1'b1, 4'd9};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_entry_buffer_ssd_scan.sv
// ssd_scan: free-running scan counter plus registered anode/nibble mux for a
// four-digit multiplexed seven-segment display.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   digit0..digit3      BCD code per position, digit0 = rightmost
//   ssd_ctl             active-low anode select (registered)
//   bcd_out             BCD code for the selected position (registered)
// The two MSBs of the counter select the position, so each digit is lit for
// 2**(SCAN_BITS-2) cycles.
module ssd_scan #(
  parameter int         SCAN_BITS = 17,
  parameter logic [3:0] BLANK     = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [3:0] ssd_ctl,
  output logic [3:0] bcd_out
);

  logic [SCAN_BITS-1:0] cnt;
  logic [1:0]           sel;

  assign sel = cnt[SCAN_BITS-1 -: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ssd_ctl <= 4'b1110;
      bcd_out <= BLANK;
    end else begin
      cnt     <= cnt + 1'b1;
      ssd_ctl <= ~(4'b0001 << sel);
      case (sel)
        2'd0:    bcd_out <= digit0;
        2'd1:    bcd_out <= digit1;
        2'd2:    bcd_out <= digit2;
        default: bcd_out <= digit3;
      endcase
    end
  end

endmodule

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: builds a 4-digit decimal entry from PS/2 make events, with
// Backspace, Esc (clear) and Enter (commit), and drives a multiplexed
// seven-segment display with either the live entry or the committed value.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   key_down       per-code key-held vector from the keyboard decoder
//   last_change    scan code of the most recent make/break
//   key_valid      decoder event strobe (rising edge = one event)
//   bcd_out        digit code for the display decoder
//   ssd_ctl        active-low anode select
//   value          last committed entry, packed BCD, MSD in [15:12]
//   commit_valid   one-cycle pulse when value updates
//   overflow       one-cycle pulse when a digit is rejected on a full entry
// Handshake: an event is the cycle where key_valid rises while the key named by
// last_change is held; it is consumed in that same cycle, there is no backpressure.
// Build option KEY_ENTRY_ZERO_PAD_EN: when defined, unused/leading positions
// show 0 instead of BLANK in ENTRY and SHOW (IDLE stays blank).
// The FSM state is kept in the signal `state` for observation.
module key_entry_buffer
  import key_entry_pkg::*;
#(
  parameter int         SCAN_BITS = 17,
  parameter logic [3:0] BLANK     = BLANK_CODE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic [3:0]   bcd_out,
  output logic [3:0]   ssd_ctl,
  output logic [15:0]  value,
  output logic         commit_valid,
  output logic         overflow
);

  logic            key_valid_q;
  logic            ev;
  logic [4:0]      dec;
  logic            is_digit, is_bksp, is_esc, is_enter;
  logic [15:0]     entry;
  logic [2:0]      count;
  logic            committed;
  state_t          state, state_d;
  logic [3:0][3:0] disp;

  // Break events leave key_down[last_change] low, so they never qualify.
  assign ev       = key_valid & ~key_valid_q & key_down[last_change];
  assign dec      = scan_to_digit(last_change);
  assign is_digit = ev & dec[4];
  assign is_bksp  = ev & (last_change == SC_BKSP);
  assign is_esc   = ev & (last_change == SC_ESC);
  assign is_enter = ev & (last_change == SC_ENTER);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic. Clearing the entry returns to SHOW only if there is a
  // committed value to show; otherwise the display goes back to blank.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (is_digit)      state_d = ENTRY;
        else if (is_enter) state_d = SHOW;
      end
      ENTRY: begin
        if (is_enter)
          state_d = SHOW;
        else if (is_esc || (is_bksp && count == 3'd1))
          state_d = committed ? SHOW : IDLE;
      end
      SHOW: begin
        if (is_digit) state_d = ENTRY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry datapath and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q  <= 1'b0;
      entry        <= 16'h0;
      count        <= 3'd0;
      value        <= 16'h0;
      committed    <= 1'b0;
      commit_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      key_valid_q  <= key_valid;
      commit_valid <= 1'b0;
      overflow     <= 1'b0;
      if (is_digit) begin
        if (count < 3'd4) begin
          entry <= {entry[11:0], dec[3:0]};
          count <= count + 3'd1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (is_bksp) begin
        if (count != 3'd0) begin
          entry <= {4'h0, entry[15:4]};
          count <= count - 3'd1;
        end
      end else if (is_esc) begin
        entry <= 16'h0;
        count <= 3'd0;
      end else if (is_enter) begin
        value        <= entry;
        commit_valid <= 1'b1;
        committed    <= 1'b1;
        entry        <= 16'h0;
        count        <= 3'd0;
      end
    end
  end

  // Output logic: per-position display source
`ifndef KEY_ENTRY_ZERO_PAD_EN
  logic lead;
`endif
  always_comb begin
    disp = {4{BLANK}};
`ifndef KEY_ENTRY_ZERO_PAD_EN
    lead = 1'b1;
`endif
    case (state)
      ENTRY: begin
        for (int i = 0; i < 4; i++) begin
`ifdef KEY_ENTRY_ZERO_PAD_EN
          disp[i] = entry[i*4 +: 4];
`else
          disp[i] = (3'(i) < count) ? entry[i*4 +: 4] : BLANK;
`endif
        end
      end
      SHOW: begin
`ifdef KEY_ENTRY_ZERO_PAD_EN
        disp = value;
`else
        // Blank zeros from the left until the first non-zero nibble; the
        // rightmost digit is always lit so a zero value still shows "0".
        for (int i = 3; i >= 1; i--) begin
          if (value[i*4 +: 4] != 4'h0) lead = 1'b0;
          disp[i] = lead ? BLANK : value[i*4 +: 4];
        end
        disp[0] = value[3:0];
`endif
      end
      default: disp = {4{BLANK}};
    endcase
  end

  ssd_scan #(
    .SCAN_BITS (SCAN_BITS),
    .BLANK     (BLANK)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .digit0  (disp[0]),
    .digit1  (disp[1]),
    .digit2  (disp[2]),
    .digit3  (disp[3]),
    .ssd_ctl (ssd_ctl),
    .bcd_out (bcd_out)
  );

endmodule

// File: tb/tb_key_entry_buffer.sv
// Testbench for key_entry_buffer: directed key sequences, committed values
// scoreboarded through exp_q, display checked by observing the scan.
module tb_key_entry_buffer;
  import key_entry_pkg::*;

  localparam logic [8:0] K0 = 9'h045, K1 = 9'h016, K2 = 9'h01E, K3 = 9'h026;
  localparam logic [8:0] K4 = 9'h025, K5 = 9'h02E, K6 = 9'h036, K7 = 9'h03D;
  localparam logic [8:0] K8 = 9'h03E, K9 = 9'h046;
  localparam logic [8:0] KBS = 9'h066, KESC = 9'h076, KENT = 9'h05A;
  localparam logic [8:0] KUNMAP = 9'h01C;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic [3:0]   bcd_out;
  logic [3:0]   ssd_ctl;
  logic [15:0]  value;
  logic         commit_valid;
  logic         overflow;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [15:0]  exp_q[$];
  logic [15:0]  exp_v;
  logic [15:0]  got;

  key_entry_buffer #(.SCAN_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_down     (key_down),
    .last_change  (last_change),
    .key_valid    (key_valid),
    .bcd_out      (bcd_out),
    .ssd_ctl      (ssd_ctl),
    .value        (value),
    .commit_valid (commit_valid),
    .overflow     (overflow)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected $finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // Comparison helper
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every commit pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL commit_unexpected: observed value %0h expected no commit", value);
      end else begin
        exp_v = exp_q.pop_front();
        assert (value === exp_v) else begin
          n_err++;
          $error("FAIL commit_value: observed %0h expected %0h", value, exp_v);
        end
      end
    end
  end

  // Driver tasks: inputs change on negedge; the event is taken at the next
  // posedge, so results are visible when the task returns.
  task automatic make(input logic [8:0] code);
    @(negedge clk);
    last_change    = code;
    key_down[code] = 1'b1;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid      = 1'b0;
    key_down[code] = 1'b0;
  endtask

  task automatic brk(input logic [8:0] code);
    @(negedge clk);
    last_change    = code;
    key_down[code] = 1'b0;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid      = 1'b0;
  endtask

  task automatic hold(input logic [8:0] code, input int cycles);
    @(negedge clk);
    last_change    = code;
    key_down[code] = 1'b1;
    key_valid      = 1'b1;
    repeat (cycles) @(negedge clk);
    key_valid      = 1'b0;
    key_down[code] = 1'b0;
  endtask

  task automatic enter_commit(input logic [15:0] expected);
    exp_q.push_back(expected);
    make(KENT);
  endtask

  // Watch a full scan period and record the nibble shown at each position.
  task automatic scan_capture(output logic [15:0] shown);
    logic [3:0] an;
    shown = 'x;
    repeat (20) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
        an = ~(4'b0001 << s);
        if (ssd_ctl === an) shown[s*4 +: 4] = bcd_out;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    key_valid   = 1'b0;
    last_change = 9'h0;
    key_down    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ssd_ctl", ssd_ctl, 4'b1110);
    check("rst_bcd_out", bcd_out, 4'hF);
    check("rst_value", value, 16'h0);
    check("rst_commit", commit_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", dut.state, IDLE);

    // Backspace and clear with nothing committed
    make(K4);
    make(K5);
    check("bs_pre_entry", dut.entry, 16'h0045);
    check("bs_pre_count", dut.count, 3'd2);
    make(KBS);
    check("bs1_entry", dut.entry, 16'h0004);
    check("bs1_count", dut.count, 3'd1);
    make(KBS);
    make(KBS);
    check("bs3_count", dut.count, 3'd0);
    check("bs3_state", dut.state, IDLE);
    check("bs3_value", value, 16'h0);

    // Break event ignored
    brk(K1);
    check("brk_count", dut.count, 3'd0);
    check("brk_state", dut.state, IDLE);

    // Entry and commit
    make(K1);
    make(K2);
    make(K3);
    check("e123_entry", dut.entry, 16'h0123);
    check("e123_count", dut.count, 3'd3);
    check("e123_state", dut.state, ENTRY);
    enter_commit(16'h0123);
    check("commit_pulse", commit_valid, 1'b1);
    check("commit_val", value, 16'h0123);
    check("commit_state", dut.state, SHOW);
    check("commit_entry_clr", dut.entry, 16'h0);
    @(negedge clk);
    check("commit_pulse_end", commit_valid, 1'b0);
    scan_capture(got);
    check("show_0123_scan", got, 16'hF123);

    // Esc in SHOW keeps the committed value
    make(KESC);
    check("esc_show_value", value, 16'h0123);
    check("esc_show_state", dut.state, SHOW);

    // Full entry and overflow
    make(K5);
    make(K6);
    make(K7);
    make(K8);
    check("full_entry", dut.entry, 16'h5678);
    check("full_count", dut.count, 3'd4);
    make(K9);
    check("ovf_pulse", overflow, 1'b1);
    check("ovf_entry", dut.entry, 16'h5678);
    @(negedge clk);
    check("ovf_pulse_end", overflow, 1'b0);

    // Unmapped key leaves everything alone
    make(KUNMAP);
    check("unmap_entry", dut.entry, 16'h5678);
    check("unmap_count", dut.count, 3'd4);
    check("unmap_state", dut.state, ENTRY);

    // Esc in ENTRY after a commit returns to SHOW
    make(KESC);
    check("esc_entry_state", dut.state, SHOW);
    check("esc_entry_clr", dut.entry, 16'h0);
    check("esc_entry_value", value, 16'h0123);

    // key_valid held high: one digit only
    hold(K7, 5);
    check("hold_entry", dut.entry, 16'h0007);
    check("hold_count", dut.count, 3'd1);

    // Reset mid-entry wins over a same-cycle event
    make(K2);
    check("pre_rst_count", dut.count, 3'd2);
    @(negedge clk);
    rst           = 1'b1;
    last_change   = K3;
    key_down[K3]  = 1'b1;
    key_valid     = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    key_valid     = 1'b0;
    key_down[K3]  = 1'b0;
    check("mrst_value", value, 16'h0);
    check("mrst_commit", commit_valid, 1'b0);
    check("mrst_overflow", overflow, 1'b0);
    check("mrst_ssd_ctl", ssd_ctl, 4'b1110);
    check("mrst_bcd_out", bcd_out, 4'hF);
    check("mrst_count", dut.count, 3'd0);
    check("mrst_entry", dut.entry, 16'h0);
    check("mrst_state", dut.state, IDLE);
    scan_capture(got);
    check("idle_scan", got, 16'hFFFF);

    // Leading-zero handling on a short committed value
    make(K4);
    make(K2);
    enter_commit(16'h0042);
    check("c42_value", value, 16'h0042);
    scan_capture(got);
`ifdef KEY_ENTRY_ZERO_PAD_EN
    check("show_0042_scan", got, 16'h0042);
`else
    check("show_0042_scan", got, 16'hFF42);
`endif

    // Every expected commit must have been seen
    repeat (2) @(negedge clk);
    check("commit_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Consumes press events from the PS/2 keyboard decoder (`key_valid`, `last_change`, `key_down`) and builds a 4-digit decimal entry with backspace, clear and Enter-to-commit editing. It drives one BCD digit at a time plus the anode select to the existing seven-segment `Display` decoder, time-multiplexing all four digits. It sits directly downstream of `KeyboardDecoder` and upstream of `Display`.

## Interface

Parameters:
- `SCAN_BITS`, default 17: width of the free-running scan counter. The digit select is `cnt[SCAN_BITS-1:SCAN_BITS-2]`.
- `BLANK`, default 4'hF: BCD code sent to `Display` for an unlit digit.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `key_down` input 512: per-code key-held vector from the decoder.
- `last_change` input 9: scan code of the most recent make or break.
- `key_valid` input 1: decoder event strobe.
- `bcd_out` output 4: digit code for `Display.ssd_in`.
- `ssd_ctl` output 4: active-low anode select.
- `value` output 16: last committed entry, four packed BCD nibbles with the MSD in [15:12].
- `commit_valid` output 1: one-cycle pulse when `value` updates.
- `overflow` output 1: one-cycle pulse when a digit is rejected because the entry is full.

## Operation

- **Event qualification.**
  - Event = rising edge of `key_valid`, taken from `key_valid & ~key_valid_q`.
  - The event must also have `key_down[last_change]==1`, so break (release) events are ignored.
  - Holding `key_valid` high produces exactly one event.
- **Key map.**
  - Digits: 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9.
  - 0x66 = backspace, 0x76 = Esc (clear), 0x5A = Enter.
  - Any other code is ignored, with no state change.
- **Entry register.** `entry[15:0]` holds four nibbles; `count` runs 0..4.
  - **Digit, count<4:** `entry <= {entry[11:0], d}`, `count+1`.
  - **Digit, count==4:** entry unchanged; `overflow` pulses.
  - **Backspace, count>0:** `entry <= {4'h0, entry[15:4]}`, `count-1`.
  - **Backspace, count==0:** no effect.
  - **Esc:** entry = 0, count = 0. `value` is untouched.
  - **Enter:** `value <= entry`, `commit_valid` pulses, then entry = 0 and count = 0. Enter with count==0 commits 0x0000.
- **State machine** (`state`):
  - IDLE: nothing committed since reset. A digit moves it to ENTRY.
  - ENTRY: count>0.
    - Enter → SHOW.
    - Esc → SHOW if a commit has occurred, else IDLE.
    - Backspace reaching count 0 follows the same rule as Esc.
  - SHOW: displaying `value`. A digit moves it to ENTRY.
- **Display source.**
  - ENTRY shows `entry`; SHOW shows `value`; IDLE shows all BLANK.
  - In ENTRY, positions at or above `count` are BLANK.
  - In SHOW, leading-zero nibbles are BLANK, except the rightmost digit, which is always shown.
- **Scan.** The counter increments every cycle and wraps. Select s=0..3 drives `ssd_ctl = ~(4'b0001<<s)` and `bcd_out` = nibble s, with s=0 as the rightmost digit.

## Timing

- An event seen in cycle N updates `entry`, `count`, `state`, `value` and the pulses at the clock edge ending N. They are visible in N+1.
- `commit_valid` and `overflow` are high only during N+1.
- `bcd_out` and `ssd_ctl` are registered: one-cycle latency from the scan counter and the display source.
- Reset values: `entry`=0, `count`=0, `value`=0, `state`=IDLE, scan counter=0, `key_valid_q`=0, `commit_valid`=0, `overflow`=0.
  - In the first cycle after reset, `ssd_ctl`=4'b1110 and `bcd_out`=BLANK.
- `rst` asserted mid-entry takes priority over a same-cycle event; the event is lost.
- Events cannot coincide, because there is one key code per edge. No event is lost while the scan advances.

## Configuration

- Macro: `KEY_ENTRY_ZERO_PAD_EN`.
- Defined: no leading-zero blanking in ENTRY or SHOW. Unused positions show 0. IDLE still shows BLANK.
- Undefined: blanking behaves as described under Operation.

## Structure

- Package `key_entry_pkg` holds:
  - scan-code localparams (digit codes, BKSP, ESC, ENTER);
  - the `BLANK` default;
  - the state enum {IDLE, ENTRY, SHOW};
  - the scan-code→digit function.
- One sub-module, `ssd_scan`: the scan counter plus the registered anode/nibble multiplexer. Its inputs are four 4-bit digits; its outputs are `ssd_ctl` and `bcd_out`.

## Test plan

- **Entry and commit.** After reset, press 1,2,3 then Enter (0x16, 0x1E, 0x26, 0x5A, make events).
  - Before Enter: entry=0x0123, count=3.
  - After Enter: `commit_valid` pulses once, `value`=0x0123, state=SHOW.
  - Scanned digits: BLANK,1,2,3.
- **Full entry.** Enter 5,6,7,8,9.
  - The fifth digit is rejected: `overflow` pulses once and entry stays 0x5678.
- **Backspace and clear.**
  - Press 4,5 then Backspace → entry=0x0004, count=1.
  - Backspace twice → count=0, state=IDLE, `value` still 0.
  - Esc in SHOW with `value`=0x0123 → `value` unchanged.
- **Release filtering.**
  - A break event (`key_down[0x16]`=0 with `key_valid`) → no change.
  - `key_valid` held high for 5 cycles on a make event → exactly one digit is accepted.
- **Reset and unmapped keys.**
  - `rst` during count=2 → all outputs at their reset values the next cycle.
  - Unmapped code 0x1C → no state change.
- **Zero pad.** With `KEY_ENTRY_ZERO_PAD_EN` defined, commit 0x0042.
  - Display shows 0,0,4,2. Without the macro: BLANK,BLANK,4,2.
